sap_control_sequencer: RTL and testbench

//  - Control sequencer for the 8-bit microcomputer. Steps a T-state ring (T1..T6) per instruction.
//  - Decodes the IR opcode nibble into the control word that drives the datapath: PC, MAR, RAM, IR, A, ALU, B, OUT.
//  - Each datapath register samples the bus on posedge clk while its load strobe is high.
//  - This block keeps load/enable strobes mutually consistent and owns halt.

---
 rtl/sap_pkg.sv | 21 ++
 rtl/sap_tstate_ring.sv | 17 +
 rtl/sap_control_sequencer.sv | 89 ++++++++
 tb/tb_sap_control_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, one-hot T-state constants and control word for the SAP sequencer (SAP_JMP_EN adds lp)
package sap_pkg;
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [5:0] T1 = 6'b000001;
  localparam logic [5:0] T2 = 6'b000010;
  localparam logic [5:0] T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000;
  localparam logic [5:0] T5 = 6'b010000;
  localparam logic [5:0] T6 = 6'b100000;
  typedef struct packed {
    logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
`ifdef SAP_JMP_EN
    logic lp;
`endif
  } ctrl_word_t;
endpackage

// File: rtl/sap_tstate_ring.sv
// sap_tstate_ring: one-hot T1..T6 ring counter with hold and restart-to-T1
module sap_tstate_ring
  import sap_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic       hold,
  input  logic       restart,
  output logic [5:0] tstate
);
  logic [5:0] r_t;
  // rotate one position per clock; hold freezes the ring, restart jumps back to T1
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_t <= T1;
    else if (!hold) r_t <= restart ? T1 : {r_t[4:0], r_t[5]};
  assign tstate = r_t;
endmodule

// File: rtl/sap_control_sequencer.sv
// sap_control_sequencer: T-state ring, opcode decode to control word and halt latch (SAP_JMP_EN adds JMP/lp)
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OPC_W     = 4,
  parameter bit SHORT_NOP = 1'b1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [OPC_W-1:0] opcode,
  output logic [5:0]       tstate,
  output logic             cp,
  output logic             ep,
  output logic             lm,
  output logic             ce,
  output logic             li,
  output logic             ei,
  output logic             la,
  output logic             ea,
  output logic             su,
  output logic             eu,
  output logic             lb,
  output logic             lo,
`ifdef SAP_JMP_EN
  output logic             lp,
`endif
  output logic             hlt
);
  logic [3:0] w_op;
  logic       w_lda, w_add, w_sub, w_out, w_hop, w_jmp, w_mem, w_alu;
  logic       w_hlt, w_restart;
  logic       r_hlt;
  ctrl_word_t w_cw;
  assign w_op  = 4'(opcode);
  assign w_lda = w_op == OP_LDA;
  assign w_add = w_op == OP_ADD;
  assign w_sub = w_op == OP_SUB;
  assign w_out = w_op == OP_OUT;
  assign w_hop = w_op == OP_HLT;
`ifdef SAP_JMP_EN
  assign w_jmp = w_op == OP_JMP;
`else
  assign w_jmp = 1'b0;
`endif
  assign w_alu = w_add | w_sub;
  assign w_mem = w_lda | w_alu;
  // halt takes effect in the T4 decode cycle itself so the ring never leaves T4
  assign w_hlt = r_hlt | (clr_n & tstate[3] & w_hop);
  // JMP and unknown opcodes count as short instructions; HLT is held instead
  assign w_restart = SHORT_NOP & tstate[3] & ~(w_mem | w_out | w_hop);
  sap_tstate_ring u_ring (
    .clk     (clk),
    .clr_n   (clr_n),
    .hold    (w_hlt),
    .restart (w_restart),
    .tstate  (tstate)
  );
  // halt latches at the first T4 of HLT and only clr_n releases it
  always_ff @(posedge clk or negedge clr_n)
    if (!clr_n) r_hlt <= 1'b0;
    else if (w_hlt) r_hlt <= 1'b1;
  // zero-latency control word; everything quiet in reset or halt
  always_comb begin
    w_cw = '0;
    if (clr_n && !w_hlt) begin
      w_cw.ep = tstate[0];
      w_cw.lm = tstate[0] | (tstate[3] & w_mem);
      w_cw.cp = tstate[1];
      w_cw.ce = tstate[2] | (tstate[4] & w_mem);
      w_cw.li = tstate[2];
      w_cw.ei = tstate[3] & (w_mem | w_jmp);
      w_cw.ea = tstate[3] & w_out;
      w_cw.lo = tstate[3] & w_out;
      w_cw.la = (tstate[4] & w_lda) | (tstate[5] & w_alu);
      w_cw.lb = tstate[4] & w_alu;
      w_cw.eu = tstate[5] & w_alu;
      w_cw.su = (tstate[4] | tstate[5]) & w_sub;
`ifdef SAP_JMP_EN
      w_cw.lp = tstate[3] & w_jmp;
`endif
    end
  end
`ifdef SAP_JMP_EN
  assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp} = w_cw;
`else
  assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = w_cw;
`endif
  assign hlt = w_hlt;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb_sap_control_sequencer: scoreboard bench for the SAP control sequencer (SAP_JMP_EN-aware)
module tb_sap_control_sequencer;
  localparam logic [5:0] T1 = 6'b000001, T2 = 6'b000010, T3 = 6'b000100;
  localparam logic [5:0] T4 = 6'b001000, T5 = 6'b010000, T6 = 6'b100000;
  localparam logic [12:0] M_CP = 13'h1000, M_EP = 13'h0800, M_LM = 13'h0400, M_CE = 13'h0200;
  localparam logic [12:0] M_LI = 13'h0100, M_EI = 13'h0080, M_LA = 13'h0040, M_EA = 13'h0020;
  localparam logic [12:0] M_SU = 13'h0010, M_EU = 13'h0008, M_LB = 13'h0004, M_LO = 13'h0002;
  localparam logic [12:0] M_LP = 13'h0001;
  logic clk = 1'b0;
  logic clr_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [5:0] tstate, tstate_l;
  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
  logic cp_l, ep_l, lm_l, ce_l, li_l, ei_l, la_l, ea_l, su_l, eu_l, lb_l, lo_l, hlt_l;
`ifdef SAP_JMP_EN
  logic lp, lp_l;
`else
  wire lp = 1'b0;
  wire lp_l = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;
  logic [19:0] q[$];
  logic [19:0] ql[$];
  always #5 clk = ~clk;
  sap_control_sequencer dut (
    .clk(clk), .clr_n(clr_n), .opcode(opcode), .tstate(tstate),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
    .su(su), .eu(eu), .lb(lb), .lo(lo),
`ifdef SAP_JMP_EN
    .lp(lp),
`endif
    .hlt(hlt)
  );
  sap_control_sequencer #(.SHORT_NOP(1'b0)) dut_l (
    .clk(clk), .clr_n(clr_n), .opcode(opcode), .tstate(tstate_l),
    .cp(cp_l), .ep(ep_l), .lm(lm_l), .ce(ce_l), .li(li_l), .ei(ei_l), .la(la_l), .ea(ea_l),
    .su(su_l), .eu(eu_l), .lb(lb_l), .lo(lo_l),
`ifdef SAP_JMP_EN
    .lp(lp_l),
`endif
    .hlt(hlt_l)
  );
  function automatic logic [19:0] ev(input logic [5:0] t, input logic h, input logic [12:0] m);
    return {t, h, m};
  endfunction
  function automatic logic [19:0] obs();
    return {tstate, hlt, cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, lp};
  endfunction
  function automatic logic [19:0] obs_l();
    return {tstate_l, hlt_l, cp_l, ep_l, lm_l, ce_l, li_l, ei_l, la_l, ea_l, su_l, eu_l, lb_l, lo_l, lp_l};
  endfunction
  task automatic push_fetch();
    q.push_back(ev(T1, 1'b0, M_EP | M_LM));
    q.push_back(ev(T2, 1'b0, M_CP));
    q.push_back(ev(T3, 1'b0, M_CE | M_LI));
  endtask
  task automatic test_reset();
    logic [19:0] e;
    logic rst_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    q.push_back(ev(T1, 1'b0, 13'h0));
    push_fetch();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clr_n = rst_tab[i]; opcode = 4'h0; #1;
      e = q.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL reset[%0d] got %h want %h", i, obs(), e); end
    end
    q.push_back(ev(T1, 1'b0, 13'h0));
    q.push_back(ev(T1, 1'b0, 13'h0));
    for (int i = 0; i < 2; i++) begin
      if (i == 1) @(negedge clk);
      clr_n = 1'b0; #1;
      e = q.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL reset_mid_t3[%0d] got %h want %h", i, obs(), e); end
    end
  endtask
  task automatic test_instr(input logic [3:0] op, input string nm);
    logic [19:0] e;
    int n;
    push_fetch();
    case (op)
      4'h0: begin
        q.push_back(ev(T4, 1'b0, M_EI | M_LM));
        q.push_back(ev(T5, 1'b0, M_CE | M_LA));
        q.push_back(ev(T6, 1'b0, 13'h0));
      end
      4'h1: begin
        q.push_back(ev(T4, 1'b0, M_EI | M_LM));
        q.push_back(ev(T5, 1'b0, M_CE | M_LB));
        q.push_back(ev(T6, 1'b0, M_EU | M_LA));
      end
      4'h2: begin
        q.push_back(ev(T4, 1'b0, M_EI | M_LM));
        q.push_back(ev(T5, 1'b0, M_CE | M_LB | M_SU));
        q.push_back(ev(T6, 1'b0, M_EU | M_LA | M_SU));
      end
      4'hE: begin
        q.push_back(ev(T4, 1'b0, M_EA | M_LO));
        q.push_back(ev(T5, 1'b0, 13'h0));
        q.push_back(ev(T6, 1'b0, 13'h0));
      end
`ifdef SAP_JMP_EN
      4'h3: q.push_back(ev(T4, 1'b0, M_EI | M_LP));
`endif
      default: q.push_back(ev(T4, 1'b0, 13'h0));
    endcase
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clr_n = 1'b1; opcode = (i < 3) ? 4'($urandom_range(0, 15)) : op; #1;
      e = q.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL %s[%0d] got %h want %h", nm, i, obs(), e); end
    end
  endtask
  task automatic test_hlt();
    logic [19:0] e;
    push_fetch();
    for (int i = 0; i < 21; i++) q.push_back(ev(T4, 1'b1, 13'h0));
    q.push_back(ev(T1, 1'b0, 13'h0));
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      clr_n = (i == 24) ? 1'b0 : 1'b1;
      opcode = (i < 3) ? 4'h0 : (i < 9) ? 4'hF : 4'h0;
      #1;
      e = q.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL hlt[%0d] got %h want %h", i, obs(), e); end
    end
  endtask
  task automatic test_nop();
    logic [19:0] e;
    q.push_back(ev(T1, 1'b0, 13'h0));
    push_fetch();
    q.push_back(ev(T4, 1'b0, 13'h0));
    push_fetch();
    ql.push_back(ev(T1, 1'b0, 13'h0));
    ql.push_back(ev(T1, 1'b0, M_EP | M_LM));
    ql.push_back(ev(T2, 1'b0, M_CP));
    ql.push_back(ev(T3, 1'b0, M_CE | M_LI));
    ql.push_back(ev(T4, 1'b0, 13'h0));
    ql.push_back(ev(T5, 1'b0, 13'h0));
    ql.push_back(ev(T6, 1'b0, 13'h0));
    ql.push_back(ev(T1, 1'b0, M_EP | M_LM));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); clr_n = (i != 0); opcode = 4'h5; #1;
      e = q.pop_front(); n_vec++;
      if (obs() !== e) begin n_err++; $display("FAIL nop_short[%0d] got %h want %h", i, obs(), e); end
      e = ql.pop_front(); n_vec++;
      if (obs_l() !== e) begin n_err++; $display("FAIL nop_long[%0d] got %h want %h", i, obs_l(), e); end
    end
  endtask
  task automatic test_random();
    logic ok, ok_l;
    @(negedge clk); clr_n = 1'b0; #1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); clr_n = 1'b1; opcode = 4'($urandom_range(0, 14)); #1;
      ok = $onehot(tstate) && $countones({ep, ce, ei, ea, eu}) <= 1 && !(cp & ep) && !(li & ei) && !(la & ea) && !hlt;
      ok_l = $onehot(tstate_l) && $countones({ep_l, ce_l, ei_l, ea_l, eu_l}) <= 1 && !(cp_l & ep_l) && !(li_l & ei_l) && !(la_l & ea_l) && !hlt_l;
      n_vec += 2;
      if (!ok) begin n_err++; $display("FAIL drivers[%0d] got %h want legal word", i, obs()); end
      if (!ok_l) begin n_err++; $display("FAIL drivers_long[%0d] got %h want legal word", i, obs_l()); end
    end
  endtask
  initial begin
    test_reset();
    test_instr(4'h0, "lda");
    test_instr(4'h1, "add");
    test_instr(4'h2, "sub");
    test_instr(4'hE, "out");
    test_instr(4'h3, "jmp");
    test_instr(4'h5, "nop");
    test_instr(4'h0, "b2b_lda");
    test_instr(4'h2, "b2b_sub");
    test_hlt();
    test_instr(4'h1, "after_hlt");
    test_nop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
